// File: rtl/mm_uart_pkg.sv
// Shared constants and state types for the memory-mapped UART.
// Register offsets, STATUS bit positions, FSM encodings and the divisor floor.
package mm_uart_pkg;

   localparam logic [1:0] OffTxData  = 2'd0;
   localparam logic [1:0] OffRxData  = 2'd1;
   localparam logic [1:0] OffStatus  = 2'd2;
   localparam logic [1:0] OffBaudDiv = 2'd3;

   localparam int unsigned StRxValid   = 0;
   localparam int unsigned StTxFull    = 1;
   localparam int unsigned StTxEmpty   = 2;
   localparam int unsigned StRxOverrun = 3;
   localparam int unsigned StTxBusy    = 4;
   localparam int unsigned StFrameErr  = 5;

   localparam logic [15:0] MinDiv = 16'd2;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < MinDiv) ? MinDiv : v;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/mm_uart.sv
// Memory-mapped UART: 4-word register window, TX FIFO feeding a serialiser,
// and a single-byte receive buffer with sticky error flags and irq.
module mm_uart
   import mm_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hC000,
   parameter int unsigned TX_DEPTH  = 4,
   parameter logic [15:0] DIV_RST   = 16'd108
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        mm_we,
   input  logic        mm_re,
   output logic [15:0] rdata,
   output logic        tx,
   input  logic        rx,
   output logic        irq
);

   logic        sel;
   logic [1:0]  off;
   logic        wr_tx, wr_div, rd_rx, rd_st;
   logic [15:0] div_q, status;

   logic        fifo_full, fifo_empty, tx_pop;
   logic [7:0]  fifo_dout;

   tx_state_e   tx_st_q;
   logic [15:0] tx_cnt_q;
   logic [2:0]  tx_bit_q;
   logic [7:0]  tx_sh_q;
   logic        tx_q;

   rx_state_e   rx_st_q;
   logic [15:0] rx_cnt_q;
   logic [2:0]  rx_bit_q;
   logic [7:0]  rx_sh_q, rx_buf_q;
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   logic        rx_valid_q, rx_ovr_q, rx_ferr_q, irq_q;

   assign sel    = (addr[15:2] == BASE_ADDR[15:2]);
   assign off    = addr[1:0];
   assign wr_tx  = sel & mm_we & (off == OffTxData);
   assign wr_div = sel & mm_we & (off == OffBaudDiv);
   assign rd_rx  = sel & mm_re & (off == OffRxData);
   assign rd_st  = sel & mm_re & (off == OffStatus);

   assign tx  = tx_q;
   assign irq = irq_q;

   always_comb begin
      status              = '0;
      status[StRxValid]   = rx_valid_q;
      status[StTxFull]    = fifo_full;
      status[StTxEmpty]   = fifo_empty;
      status[StRxOverrun] = rx_ovr_q;
      status[StTxBusy]    = (tx_st_q != TxIdle);
      status[StFrameErr]  = rx_ferr_q;
   end

   always_comb begin
      rdata = '0;
      if (sel && mm_re) begin
         case (off)
            OffRxData:  rdata = {8'h00, rx_buf_q};
            OffStatus:  rdata = status;
            OffBaudDiv: rdata = div_q;
            default:    rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         div_q <= DIV_RST;
      else if (wr_div) div_q <= clamp_div(wdata);
   end

   // Pop when idle, or at the end of a stop bit so frames run back-to-back.
   assign tx_pop = ~fifo_empty &
                   ((tx_st_q == TxIdle) || ((tx_st_q == TxStop) && (tx_cnt_q == '0)));

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_tx),
      .pop_i   (tx_pop),
      .din_i   (wdata[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st_q  <= TxIdle;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (tx_st_q)
            TxIdle: begin
               if (tx_pop) begin
                  tx_sh_q  <= fifo_dout;
                  tx_q     <= 1'b0;
                  tx_cnt_q <= div_q - 16'd1;
                  tx_st_q  <= TxStart;
               end
            end
            TxStart: begin
               if (tx_cnt_q == '0) begin
                  tx_q     <= tx_sh_q[0];
                  tx_sh_q  <= tx_sh_q >> 1;
                  tx_bit_q <= '0;
                  tx_cnt_q <= div_q - 16'd1;
                  tx_st_q  <= TxData;
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            TxData: begin
               if (tx_cnt_q == '0) begin
                  tx_cnt_q <= div_q - 16'd1;
                  if (tx_bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     tx_st_q <= TxStop;
                  end else begin
                     tx_q     <= tx_sh_q[0];
                     tx_sh_q  <= tx_sh_q >> 1;
                     tx_bit_q <= tx_bit_q + 3'd1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            default: begin
               if (tx_cnt_q != '0) begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end else if (tx_pop) begin
                  tx_sh_q  <= fifo_dout;
                  tx_q     <= 1'b0;
                  tx_cnt_q <= div_q - 16'd1;
                  tx_st_q  <= TxStart;
               end else begin
                  tx_st_q <= TxIdle;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_st_q    <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_buf_q   <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         irq_q     <= rx_valid_q;
         if (rd_rx) rx_valid_q <= 1'b0;
         if (rd_st) begin
            rx_ovr_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
         end
         case (rx_st_q)
            RxIdle: begin
               if (rx_prev_q && !rx_sync_q) begin
                  rx_cnt_q <= {1'b0, div_q[15:1]} - 16'd1;
                  rx_st_q  <= RxStart;
               end
            end
            RxStart: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end else if (rx_sync_q) begin
                  rx_st_q <= RxIdle;
               end else begin
                  rx_bit_q <= '0;
                  rx_cnt_q <= div_q - 16'd1;
                  rx_st_q  <= RxData;
               end
            end
            RxData: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end else begin
                  rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                  rx_bit_q <= rx_bit_q + 3'd1;
                  rx_cnt_q <= div_q - 16'd1;
                  if (rx_bit_q == 3'd7) rx_st_q <= RxStop;
               end
            end
            default: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end else begin
                  // A same-edge RXDATA pop loses to the new byte and is not an overrun.
                  if (rx_sync_q) begin
                     rx_buf_q   <= rx_sh_q;
                     rx_valid_q <= 1'b1;
                     if (rx_valid_q && !rd_rx) rx_ovr_q <= 1'b1;
                  end else begin
                     rx_ferr_q <= 1'b1;
                  end
                  rx_st_q <= RxIdle;
               end
            end
         endcase
      end
   end

endmodule
